// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning stage.
package btn_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;

    // Timing defaults for a 100 MHz clock.
    localparam int DEF_N_BTN           = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    typedef enum logic [1:0] {
        RPT_IDLE      = 2'd0,
        RPT_ARMED     = 2'd1,
        RPT_REPEATING = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// pulses and the hold-to-repeat FSM.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [RCW-1:0] RP_LAST = RCW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    logic [1:0]     sync_q;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           repeat_q, repeat_d;
    rpt_state_e     state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           s;

    assign s = sync_q[1];

    // Any cycle where s agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s != level_q) begin
            if (cnt_q == DC_LAST) begin
                level_d   = s;
                press_d   = s;
                release_d = ~s;
            end else begin
                cnt_d = cnt_q + DCW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        if (REPEAT_DELAY != 0) begin
            unique case (state_q)
                RPT_IDLE: begin
                    if (press_d) begin
                        state_d = RPT_ARMED;
                        rcnt_d  = '0;
                    end
                end
                RPT_ARMED: begin
                    if (release_d) begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                        state_d  = RPT_REPEATING;
                    end else begin
                        rcnt_d = rcnt_q + RCW'(1);
                    end
                end
                RPT_REPEATING: begin
                    if (release_d) begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCW'(1);
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= RPT_IDLE;
            rcnt_q    <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into clean levels and one-cycle
// press/release/repeat pulses; channels are fully independent.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .btn_i     (btn_in[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .repeat_o  (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse events are queued when
// buttons are driven and matched cycle by cycle against the outputs.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int LAT = DB + 2;
    localparam int K_PRS = 0, K_REL = 1, K_RPT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_in, lvl, prs, rel, rpt;
    logic [2:0] nr_in, nr_lvl, nr_prs, nr_rel, nr_rpt;

    btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl),
        .btn_press(prs), .btn_release(rel), .btn_repeat(rpt));

    btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut_nr (
        .clk(clk), .rst(rst), .btn_in(nr_in), .btn_level(nr_lvl),
        .btn_press(nr_prs), .btn_release(nr_rel), .btn_repeat(nr_rpt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int kind; int ch;} ev_t;
    ev_t sb[$];

    int         checks = 0, failures = 0;
    bit         mon_en = 1'b0;
    logic [2:0] lvl_m = '0;
    logic [2:0] ep, er, erp;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push(input int c, input int k, input int ch);
        ev_t e;
        e.cyc = c; e.kind = k; e.ch = ch;
        sb.push_back(e);
    endtask

    // Button rises (first sampled at t_rise+1) and drops (first sampled at t_drop+1).
    task automatic hold(input int ch, input int t_rise, input int t_drop);
        int p, r;
        p = t_rise + LAT;
        r = t_drop + LAT;
        push(p, K_PRS, ch);
        for (int t = p + RD; t < r; t += RP) push(t, K_RPT, ch);
        push(r, K_REL, ch);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            ep = '0; er = '0; erp = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        K_PRS:   ep[sb[i].ch]  = 1'b1;
                        K_REL:   er[sb[i].ch]  = 1'b1;
                        default: erp[sb[i].ch] = 1'b1;
                    endcase
                    sb.delete(i);
                end
            end
            lvl_m = (lvl_m | ep) & ~er;
            chk("press",   prs, ep);
            chk("release", rel, er);
            chk("repeat",  rpt, erp);
            chk("level",   lvl, lvl_m);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2, r, np, nrp, pcyc;
        logic [4:0] pat;

        rst = 1'b1; btn_in = '0; nr_in = '0;
        tick(3);
        chk("rst_level", lvl, 3'b000);
        chk("rst_press", prs, 3'b000);
        chk("rst_release", rel, 3'b000);
        chk("rst_repeat", rpt, 3'b000);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Clean press on up, repeat train, release.
        t = cyc;
        btn_in[BTN_U] = 1'b1;
        hold(BTN_U, t, t + 23);
        wait_cyc(t + 23);
        btn_in[BTN_U] = 1'b0;
        wait_cyc(t + 23 + LAT + 3);

        // Bounce on centre: 1,0,1,1,0 must never be accepted.
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            btn_in[BTN_C] = pat[i];
            tick(1);
        end
        btn_in[BTN_C] = 1'b0;
        tick(8);
        t2 = cyc;
        btn_in[BTN_C] = 1'b1;
        hold(BTN_C, t2, t2 + 7);
        wait_cyc(t2 + 7);
        btn_in[BTN_C] = 1'b0;
        wait_cyc(t2 + 16);

        // Down released exactly when the second repeat would be due.
        t = cyc;
        btn_in[BTN_D] = 1'b1;
        hold(BTN_D, t, t + 15);
        wait_cyc(t + 15);
        btn_in[BTN_D] = 1'b0;
        wait_cyc(t + 25);

        // All three together.
        t = cyc;
        btn_in = 3'b111;
        for (int c = 0; c < 3; c++) hold(c, t, t + 30);
        wait_cyc(t + 30);
        btn_in = 3'b000;
        wait_cyc(t + 40);

        // Reset while up is in REPEATING with the button still held.
        t = cyc;
        btn_in[BTN_U] = 1'b1;
        push(t + LAT, K_PRS, BTN_U);
        push(t + LAT + RD, K_RPT, BTN_U);
        push(t + LAT + RD + RP, K_RPT, BTN_U);
        wait_cyc(t + 23);
        rst = 1'b1;
        mon_en = 1'b0;
        sb.delete();
        lvl_m = '0;
        #1;
        chk("midrst_level", lvl, 3'b000);
        chk("midrst_press", prs, 3'b000);
        chk("midrst_release", rel, 3'b000);
        chk("midrst_repeat", rpt, 3'b000);
        tick(3);
        rst = 1'b0;
        r = cyc;
        mon_en = 1'b1;
        hold(BTN_U, r, r + 20);
        wait_cyc(r + 20);
        btn_in[BTN_U] = 1'b0;
        wait_cyc(r + 30);

        // Repeat disabled instance: one press, no repeats over a long hold.
        t = cyc;
        nr_in[BTN_C] = 1'b1;
        np = 0; nrp = 0; pcyc = -1;
        repeat (100) begin
            @(negedge clk);
            if (nr_prs[BTN_C]) begin np++; pcyc = cyc; end
            if (nr_rpt != 3'b000) nrp++;
        end
        chk_int("nr_press_count", np, 1);
        chk_int("nr_press_cycle", pcyc, t + LAT);
        chk_int("nr_repeat_count", nrp, 0);
        chk("nr_level", nr_lvl, 3'b001);
        nr_in = '0;
        tick(2);

        chk_int("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
